// File: rtl/ws2812b_decoder.sv
// ws2812b_decoder: recovers 24-bit GRB pixel words, their position in the
// frame and frame boundaries from a WS2812B single-wire stream. Bit values
// are decided purely by the width of each high pulse; a long low period
// (latch) ends a frame.
module ws2812b_decoder #(
    parameter int THRESHOLD_CYCLES = 60,
    parameter int RESET_CYCLES     = 5000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    output logic [23:0] pixel_data,
    output logic [7:0]  pixel_index,
    output logic        pixel_valid,
    output logic        frame_done,
    output logic        error
);

    localparam int CW = $clog2(RESET_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(RESET_CYCLES);
    localparam logic [CW-1:0] CNT_THR  = CW'(THRESHOLD_CYCLES);

    typedef enum logic [1:0] {
        WAIT_LATCH = 2'd0,
        IDLE       = 2'd1,
        HIGH       = 2'd2,
        LOW        = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          prev_q, prev_d;

    logic [CW-1:0] hi_cnt_q, hi_cnt_d;
    logic [CW-1:0] lo_cnt_q, lo_cnt_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic [23:0]   shift_q, shift_d;
    logic [7:0]    next_index_q, next_index_d;

    logic          emit_q, emit_d;
    logic [7:0]    emit_index_q, emit_index_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [23:0]   pixel_data_q, pixel_data_d;
    logic [7:0]    pixel_index_q, pixel_index_d;
    logic          pixel_valid_q, pixel_valid_d;
    logic          frame_done_q, frame_done_d;
    logic          error_q, error_d;

    logic          line_rise;
    logic          line_fall;
    logic          hi_sat;
    logic          lo_sat;
    logic          bit_value;
    logic          last_bit;
    logic [CW-1:0] hi_inc;
    logic [CW-1:0] lo_inc;

    // Edge detection and counter helpers on the synchronized line
    always_comb begin
        line_rise = sync2_q & ~prev_q;
        line_fall = ~sync2_q & prev_q;
        hi_sat    = (hi_cnt_q == CNT_MAX);
        lo_sat    = (lo_cnt_q == CNT_MAX);
        hi_inc    = hi_sat ? hi_cnt_q : hi_cnt_q + CNT_ONE;
        lo_inc    = lo_sat ? lo_cnt_q : lo_cnt_q + CNT_ONE;
        bit_value = (hi_cnt_q >= CNT_THR);
        last_bit  = (bit_cnt_q == 5'd23);
    end

    // State register and every other flop, cleared together on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= WAIT_LATCH;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            prev_q        <= 1'b0;
            hi_cnt_q      <= CNT_ZERO;
            lo_cnt_q      <= CNT_ZERO;
            bit_cnt_q     <= 5'd0;
            shift_q       <= 24'd0;
            next_index_q  <= 8'd0;
            emit_q        <= 1'b0;
            emit_index_q  <= 8'd0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            pixel_data_q  <= 24'd0;
            pixel_index_q <= 8'd0;
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            prev_q        <= prev_d;
            hi_cnt_q      <= hi_cnt_d;
            lo_cnt_q      <= lo_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            next_index_q  <= next_index_d;
            emit_q        <= emit_d;
            emit_index_q  <= emit_index_d;
            done_q        <= done_d;
            err_q         <= err_d;
            pixel_data_q  <= pixel_data_d;
            pixel_index_q <= pixel_index_d;
            pixel_valid_q <= pixel_valid_d;
            frame_done_q  <= frame_done_d;
            error_q       <= error_d;
        end
    end

    // Next-state logic: decoding only starts after a full latch period
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_LATCH: begin
                if (lo_sat) begin
                    state_d = line_rise ? HIGH : IDLE;
                end
            end
            IDLE: begin
                if (line_rise) begin
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (line_fall) begin
                    state_d = LOW;
                end else if (hi_sat) begin
                    state_d = WAIT_LATCH;
                end
            end
            LOW: begin
                if (line_rise) begin
                    state_d = HIGH;
                end else if (lo_sat) begin
                    state_d = IDLE;
                end
            end
            default: state_d = WAIT_LATCH;
        endcase
    end

    // Datapath: counters, bit assembly and event flags for each state
    always_comb begin
        sync1_d      = din;
        sync2_d      = sync1_q;
        prev_d       = sync2_q;
        hi_cnt_d     = hi_cnt_q;
        lo_cnt_d     = lo_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        next_index_d = next_index_q;
        emit_d       = 1'b0;
        emit_index_d = emit_index_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            WAIT_LATCH: begin
                hi_cnt_d = CNT_ZERO;
                lo_cnt_d = sync2_q ? CNT_ZERO : lo_inc;
                if (lo_sat && line_rise) begin
                    hi_cnt_d = CNT_ONE;
                end
            end
            IDLE: begin
                lo_cnt_d = CNT_ZERO;
                if (line_rise) begin
                    hi_cnt_d = CNT_ONE;
                end
            end
            HIGH: begin
                if (line_fall) begin
                    shift_d  = {shift_q[22:0], bit_value};
                    lo_cnt_d = CNT_ONE;
                    if (last_bit) begin
                        bit_cnt_d    = 5'd0;
                        emit_d       = 1'b1;
                        emit_index_d = next_index_q;
                        next_index_d = next_index_q + 8'd1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end else if (hi_sat) begin
                    err_d        = 1'b1;
                    bit_cnt_d    = 5'd0;
                    next_index_d = 8'd0;
                    shift_d      = 24'd0;
                    lo_cnt_d     = CNT_ZERO;
                    hi_cnt_d     = CNT_ZERO;
                end else begin
                    hi_cnt_d = hi_inc;
                end
            end
            LOW: begin
                if (line_rise) begin
                    hi_cnt_d = CNT_ONE;
                end else if (lo_sat) begin
                    done_d       = 1'b1;
                    err_d        = (bit_cnt_q != 5'd0);
                    bit_cnt_d    = 5'd0;
                    next_index_d = 8'd0;
                    shift_d      = 24'd0;
                    lo_cnt_d     = CNT_ZERO;
                end else begin
                    lo_cnt_d = lo_inc;
                end
            end
            default: begin
                hi_cnt_d = CNT_ZERO;
                lo_cnt_d = CNT_ZERO;
            end
        endcase
    end

    // Output stage: publishes the staged events one cycle later, holding
    // pixel_data and pixel_index steady between pixel_valid pulses
    always_comb begin
        pixel_valid_d = emit_q;
        frame_done_d  = done_q;
        error_d       = err_q;
        pixel_data_d  = emit_q ? shift_q : pixel_data_q;
        pixel_index_d = emit_q ? emit_index_q : pixel_index_q;
    end

    assign pixel_data  = pixel_data_q;
    assign pixel_index = pixel_index_q;
    assign pixel_valid = pixel_valid_q;
    assign frame_done  = frame_done_q;
    assign error       = error_q;

endmodule

// File: tb/tb_ws2812b_decoder.sv
// tb_ws2812b_decoder: directed WS2812B frames with a scoreboard of expected
// output events checked by an independent monitor. Timing parameters are
// scaled down so a 257-pixel frame fits a short run.
module tb_ws2812b_decoder;

    localparam int THR        = 4;
    localparam int RST        = 64;
    localparam int HI_ONE     = 6;
    localparam int HI_ZERO    = 2;
    localparam int LO_GAP     = 3;
    localparam int LATCH_HOLD = RST + 16;
    localparam int RECOVER    = RST + 36;

    localparam logic [2:0] EV_PIXEL    = 3'b100;
    localparam logic [2:0] EV_DONE     = 3'b010;
    localparam logic [2:0] EV_ERR      = 3'b001;
    localparam logic [2:0] EV_DONE_ERR = 3'b011;

    logic        clk;
    logic        reset;
    logic        din;
    logic [23:0] pixel_data;
    logic [7:0]  pixel_index;
    logic        pixel_valid;
    logic        frame_done;
    logic        error;

    typedef struct {
        logic [2:0]  code;
        logic [23:0] data;
        logic [7:0]  index;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       exp_item;
    logic [2:0] act_code;
    int         checks   = 0;
    int         failures = 0;

    ws2812b_decoder #(
        .THRESHOLD_CYCLES(THR),
        .RESET_CYCLES    (RST)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .pixel_data (pixel_data),
        .pixel_index(pixel_index),
        .pixel_valid(pixel_valid),
        .frame_done (frame_done),
        .error      (error)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the bench always terminates
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic expect_pixel(input logic [23:0] data, input logic [7:0] index);
        exp_q.push_back('{EV_PIXEL, data, index});
    endtask

    task automatic expect_event(input logic [2:0] code);
        exp_q.push_back('{code, 24'd0, 8'd0});
    endtask

    task automatic send_bit_width(input int hi);
        din = 1'b1;
        repeat (hi) @(negedge clk);
        din = 1'b0;
        repeat (LO_GAP) @(negedge clk);
    endtask

    task automatic send_bits(input logic [23:0] word, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            send_bit_width(word[23 - i] ? HI_ONE : HI_ZERO);
        end
    endtask

    task automatic hold_low(input int cycles);
        din = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_pixel_data"},  32'(pixel_data),  32'd0);
        check_output({tag, "_pixel_index"}, 32'(pixel_index), 32'd0);
        check_output({tag, "_pixel_valid"}, 32'(pixel_valid), 32'd0);
        check_output({tag, "_frame_done"},  32'(frame_done),  32'd0);
        check_output({tag, "_error"},       32'(error),       32'd0);
    endtask

    function automatic logic [23:0] wrap_pattern(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b, b ^ 8'hA5, 8'h3C};
    endfunction

    // Monitor: every output event must match the head of the scoreboard
    always @(posedge clk) begin
        #1;
        if (pixel_valid || frame_done || error) begin
            act_code = {pixel_valid, frame_done, error};
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_event actual=%b required=none", act_code);
            end else begin
                exp_item = exp_q.pop_front();
                check_output("event_kind", 32'(act_code), 32'(exp_item.code));
                if (exp_item.code == EV_PIXEL) begin
                    check_output("pixel_data", 32'(pixel_data), 32'(exp_item.data));
                    check_output("pixel_index", 32'(pixel_index), 32'(exp_item.index));
                end
            end
        end
    end

    // Directed scenarios
    task automatic apply_stimulus();
        // Reset state
        reset = 1'b1;
        din   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        hold_low(RECOVER);

        // Single pixel
        expect_pixel(24'hA53CF0, 8'd0);
        send_bits(24'hA53CF0, 24);
        expect_event(EV_DONE);
        hold_low(LATCH_HOLD);

        // Three pixels per frame, frame sent twice
        for (int f = 0; f < 2; f++) begin
            expect_pixel(24'hFFFFFF, 8'd0);
            send_bits(24'hFFFFFF, 24);
            expect_pixel(24'h000000, 8'd1);
            send_bits(24'h000000, 24);
            expect_pixel(24'h123456, 8'd2);
            send_bits(24'h123456, 24);
            expect_event(EV_DONE);
            hold_low(LATCH_HOLD);
        end

        // Threshold boundary: just below, just above, exactly at
        expect_pixel(24'h000000, 8'd0);
        for (int i = 0; i < 24; i++) send_bit_width(THR - 1);
        expect_pixel(24'hFFFFFF, 8'd1);
        for (int i = 0; i < 24; i++) send_bit_width(THR + 1);
        expect_pixel(24'hFFFFFF, 8'd2);
        for (int i = 0; i < 24; i++) send_bit_width(THR);
        expect_event(EV_DONE);
        hold_low(LATCH_HOLD);

        // Partial pixel then latch
        expect_event(EV_DONE_ERR);
        send_bits(24'hABCDEF, 10);
        hold_low(LATCH_HOLD);
        expect_pixel(24'h0F0F0F, 8'd0);
        send_bits(24'h0F0F0F, 24);
        expect_event(EV_DONE);
        hold_low(LATCH_HOLD);

        // Line stuck high mid-pixel
        send_bits(24'hFEDCBA, 7);
        expect_event(EV_ERR);
        din = 1'b1;
        repeat (RST + 40) @(negedge clk);
        hold_low(RECOVER);
        expect_pixel(24'h13579B, 8'd0);
        send_bits(24'h13579B, 24);
        expect_event(EV_DONE);
        hold_low(LATCH_HOLD);

        // 257 pixels in one frame: index wraps back to 0
        for (int i = 0; i < 257; i++) begin
            expect_pixel(wrap_pattern(i), 8'(i));
            send_bits(wrap_pattern(i), 24);
        end
        repeat (5) @(negedge clk);
        check_output("wrap_last_index", 32'(pixel_index), 32'd0);
        check_output("wrap_last_data", 32'(pixel_data), 32'(wrap_pattern(256)));

        // Reset during the 12th bit of the next pixel
        send_bits(24'h800FFF, 11);
        din = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("midreset");
        reset = 1'b0;
        repeat (4) @(negedge clk);
        din = 1'b0;
        repeat (LO_GAP) @(negedge clk);
        send_bits(24'hABC000, 12);
        send_bits(24'h5A5A5A, 24);
        hold_low(RECOVER);
        expect_pixel(24'hC0FFEE, 8'd0);
        send_bits(24'hC0FFEE, 24);
        expect_event(EV_DONE);
        hold_low(LATCH_HOLD);
    endtask

    initial begin
        apply_stimulus();
        repeat (20) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL pending_events actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
